// File: rtl/fb_port_a_scheduler_pkg.sv
// Shared frame-buffer constants and enums for the port A scheduler slice.
//   FB_ADDR_W / FB_DATA_W / FB_PIX_W : word address, plane word and pixel widths
//   FB_RD_LAT                        : memory read latency seen on port A
//   client_e                         : client id carried with read data
//   state_e                          : scheduler / clear sequencer state
package fb_port_a_scheduler_pkg;

  localparam int FB_ADDR_W = 10;
  localparam int FB_DATA_W = 256;
  localparam int FB_PIX_W  = 8;
  localparam int FB_RD_LAT = 2;

  typedef enum logic {
    CL_RASTER = 1'b0,
    CL_READ   = 1'b1
  } client_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Read tag pipeline: carries {valid, client} alongside the memory read latency
// so that returning data can be flagged and attributed to its requester.
//   clock_i, reset_i : clock, synchronous active-high reset (flushes the pipe)
//   valid_i          : a read was issued this cycle
//   client_i         : id of the client that issued it
//   valid_o          : tagged read data valid (RD_LAT cycles after issue)
//   client_o         : id belonging to the data now on the memory outputs
module fb_rd_tag_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic valid_i,
  input  logic client_i,
  output logic valid_o,
  output logic client_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] client_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q  <= '0;
      client_q <= '0;
    end else begin
      valid_q[0]  <= valid_i;
      client_q[0] <= client_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i]  <= valid_q[i-1];
        client_q[i] <= client_q[i-1];
      end
    end
  end

  assign valid_o  = valid_q[RD_LAT-1];
  assign client_o = client_q[RD_LAT-1];

endmodule

// File: rtl/fb_port_a_scheduler.sv
// Port A scheduler of the R/G/B frame-buffer memory.
// Round-robin arbitrates the raster writer (c0) and the readback reader (c1)
// onto the single read/write port, runs a full-buffer clear that pre-empts both
// clients, and returns read data tagged with its originating client.
//   clock_i, reset_i        : clock (also memory clock_a), sync active-high reset
//   cN_*_i / cN_gnt_o       : client request, direction, address, plane data, grant pulse
//   rd_valid_o/rd_client_o  : tagged read return, rd_r/g/b_o carry the plane data
//   clr_start_i, clr_*_i    : clear trigger and colour; clr_busy_o, clr_done_o status
//   mem_*_o / mem_q*_i      : memory port A control, address, write and read data
//
// state    | meaning
// ST_IDLE  | arbitrate client requests, accept clr_start
// ST_CLEAR | write clear colour to address 0..DEPTH-1, one word per cycle
// ST_DONE  | single cycle, clr_done_o pulse, then back to ST_IDLE
module fb_port_a_scheduler
  import fb_port_a_scheduler_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int PIX_W  = FB_PIX_W,
  parameter int RD_LAT = FB_RD_LAT
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              c0_req_i,
  input  logic              c0_we_i,
  input  logic [ADDR_W-1:0] c0_addr_i,
  input  logic [DATA_W-1:0] c0_r_i,
  input  logic [DATA_W-1:0] c0_g_i,
  input  logic [DATA_W-1:0] c0_b_i,
  output logic              c0_gnt_o,
  input  logic              c1_req_i,
  input  logic              c1_we_i,
  input  logic [ADDR_W-1:0] c1_addr_i,
  input  logic [DATA_W-1:0] c1_r_i,
  input  logic [DATA_W-1:0] c1_g_i,
  input  logic [DATA_W-1:0] c1_b_i,
  output logic              c1_gnt_o,
  output logic              rd_valid_o,
  output logic              rd_client_o,
  output logic [DATA_W-1:0] rd_r_o,
  output logic [DATA_W-1:0] rd_g_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              clr_start_i,
  input  logic [PIX_W-1:0]  clr_r_i,
  input  logic [PIX_W-1:0]  clr_g_i,
  input  logic [PIX_W-1:0]  clr_b_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              mem_clk_en_o,
  output logic              mem_wren_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_r_o,
  output logic [DATA_W-1:0] mem_g_o,
  output logic [DATA_W-1:0] mem_b_o,
  input  logic [DATA_W-1:0] mem_qr_i,
  input  logic [DATA_W-1:0] mem_qg_i,
  input  logic [DATA_W-1:0] mem_qb_i
);

  localparam int PIX_PER_WORD = DATA_W / PIX_W;

  state_e            state_q, state_d;
  client_e           rr_q, rr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              sel_c1;
  logic              rd_issue;
  client_e           issue_client;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= CL_RASTER;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // c1 wins when it is the only requester, or when both ask and the pointer is on it.
  assign sel_c1 = c1_req_i && (!c0_req_i || (rr_q == CL_READ));

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    clr_cnt_d    = clr_cnt_q;
    c0_gnt_o     = 1'b0;
    c1_gnt_o     = 1'b0;
    mem_clk_en_o = 1'b0;
    mem_wren_o   = 1'b0;
    mem_addr_o   = '0;
    mem_r_o      = '0;
    mem_g_o      = '0;
    mem_b_o      = '0;
    clr_busy_o   = 1'b0;
    clr_done_o   = 1'b0;
    issue_client = CL_RASTER;

    // Gating on reset keeps every output quiet while reset is held, even with
    // requests pending.
    if (!reset_i) begin
      unique case (state_q)
        ST_IDLE: begin
          clr_cnt_d = '0;
          if (clr_start_i) begin
            state_d = ST_CLEAR;
          end else if (c0_req_i || c1_req_i) begin
            mem_clk_en_o = 1'b1;
            if (c0_req_i && c1_req_i) begin
              rr_d = sel_c1 ? CL_RASTER : CL_READ;
            end
            if (sel_c1) begin
              c1_gnt_o     = 1'b1;
              mem_wren_o   = c1_we_i;
              mem_addr_o   = c1_addr_i;
              mem_r_o      = c1_r_i;
              mem_g_o      = c1_g_i;
              mem_b_o      = c1_b_i;
              issue_client = CL_READ;
            end else begin
              c0_gnt_o     = 1'b1;
              mem_wren_o   = c0_we_i;
              mem_addr_o   = c0_addr_i;
              mem_r_o      = c0_r_i;
              mem_g_o      = c0_g_i;
              mem_b_o      = c0_b_i;
              issue_client = CL_RASTER;
            end
          end
        end
        ST_CLEAR: begin
          clr_busy_o   = 1'b1;
          mem_clk_en_o = 1'b1;
          mem_wren_o   = 1'b1;
          mem_addr_o   = clr_cnt_q;
          mem_r_o      = {PIX_PER_WORD{clr_r_i}};
          mem_g_o      = {PIX_PER_WORD{clr_g_i}};
          mem_b_o      = {PIX_PER_WORD{clr_b_i}};
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          end
        end
        ST_DONE: begin
          clr_done_o = 1'b1;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign rd_issue = mem_clk_en_o && !mem_wren_o;

  fb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .valid_i  (rd_issue),
    .client_i (issue_client),
    .valid_o  (rd_valid_o),
    .client_o (rd_client_o)
  );

  // Data is forced to zero outside a valid return so the outputs are clean in reset.
  assign rd_r_o = rd_valid_o ? mem_qr_i : '0;
  assign rd_g_o = rd_valid_o ? mem_qg_i : '0;
  assign rd_b_o = rd_valid_o ? mem_qb_i : '0;

endmodule

// File: tb/tb_fb_port_a_scheduler.sv
module tb_fb_port_a_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic         c0_req, c0_we, c1_req, c1_we;
  logic [9:0]   c0_addr, c1_addr;
  logic [255:0] c0_r, c0_g, c0_b, c1_r, c1_g, c1_b;
  logic         c0_gnt, c1_gnt, rd_valid, rd_client;
  logic [255:0] rd_r, rd_g, rd_b;
  logic         clr_start;
  logic [7:0]   clr_r, clr_g, clr_b;
  logic         clr_busy, clr_done, mem_clk_en, mem_wren;
  logic [9:0]   mem_addr;
  logic [255:0] mem_r, mem_g, mem_b, mem_qr, mem_qg, mem_qb;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fb_port_a_scheduler dut (
    .clock_i(clock), .reset_i(reset),
    .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_addr_i(c0_addr),
    .c0_r_i(c0_r), .c0_g_i(c0_g), .c0_b_i(c0_b), .c0_gnt_o(c0_gnt),
    .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_addr_i(c1_addr),
    .c1_r_i(c1_r), .c1_g_i(c1_g), .c1_b_i(c1_b), .c1_gnt_o(c1_gnt),
    .rd_valid_o(rd_valid), .rd_client_o(rd_client),
    .rd_r_o(rd_r), .rd_g_o(rd_g), .rd_b_o(rd_b),
    .clr_start_i(clr_start), .clr_r_i(clr_r), .clr_g_i(clr_g), .clr_b_i(clr_b),
    .clr_busy_o(clr_busy), .clr_done_o(clr_done),
    .mem_clk_en_o(mem_clk_en), .mem_wren_o(mem_wren), .mem_addr_o(mem_addr),
    .mem_r_o(mem_r), .mem_g_o(mem_g), .mem_b_o(mem_b),
    .mem_qr_i(mem_qr), .mem_qg_i(mem_qg), .mem_qb_i(mem_qb)
  );

  // Memory model: registered address, registered output -> 2-cycle read latency.
  logic [255:0] ram_r [1024];
  logic [255:0] ram_g [1024];
  logic [255:0] ram_b [1024];
  logic [9:0]   ram_addr_q = '0;

  always @(posedge clock) begin
    if (mem_clk_en) begin
      ram_addr_q <= mem_addr;
      if (mem_wren) begin
        ram_r[mem_addr] <= mem_r;
        ram_g[mem_addr] <= mem_g;
        ram_b[mem_addr] <= mem_b;
      end
    end
    mem_qr <= ram_r[ram_addr_q];
    mem_qg <= ram_g[ram_addr_q];
    mem_qb <= ram_b[ram_addr_q];
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Issue a c1 read and return what appears RD_LAT cycles after the grant.
  task automatic do_read(input logic [9:0] addr, output logic ok, output logic vld,
                         output logic cl, output logic [255:0] r, output logic [255:0] g,
                         output logic [255:0] b);
    ok = 1'b0;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = addr;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (c1_gnt) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    c1_req = 1'b0;
    cyc();
    #1;
    vld = rd_valid; cl = rd_client; r = rd_r; g = rd_g; b = rd_b;
    cyc();
  endtask

  task automatic wait_clear_end(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      #1;
      if (clr_done) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; c0_req = 1'b1; c0_we = 1'b1; c0_addr = 10'd3;
    cyc(); cyc();
    #1;
    checks++;
    if ({c0_gnt, c1_gnt, rd_valid, rd_client, clr_busy, clr_done, mem_clk_en, mem_wren} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {c0_gnt, c1_gnt, rd_valid, rd_client, clr_busy, clr_done, mem_clk_en, mem_wren});
    end
    checks++;
    if (mem_addr !== 10'd0 || mem_r !== '0 || rd_r !== '0) begin
      failures++;
      $display("FAIL reset_data: mem_addr=%0d mem_r_zero=%0b rd_r_zero=%0b want 0/1/1",
               mem_addr, mem_r == '0, rd_r == '0);
    end
    c0_req = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    logic [255:0] er, eg, eb;
    er = {32{8'hA1}}; eg = {32{8'hB2}}; eb = {32{8'hC3}};
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 10'd5; c0_r = er; c0_g = eg; c0_b = eb;
    #1;
    checks++;
    if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0 || mem_clk_en !== 1'b1 || mem_wren !== 1'b1 ||
        mem_addr !== 10'd5 || mem_r !== er || mem_b !== eb) begin
      failures++;
      $display("FAIL wr_grant: gnt0=%b gnt1=%b en=%b we=%b addr=%0d want 1 0 1 1 5",
               c0_gnt, c1_gnt, mem_clk_en, mem_wren, mem_addr);
    end
    cyc();
    c0_req = 1'b0;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 10'd5;
    #1;
    checks++;
    if (c1_gnt !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 10'd5) begin
      failures++;
      $display("FAIL rd_grant: gnt1=%b we=%b addr=%0d want 1 0 5", c1_gnt, mem_wren, mem_addr);
    end
    cyc();
    c1_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_early: rd_valid=%b want 0 one cycle after grant", rd_valid);
    end
    cyc();
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_client !== 1'b1 || rd_r !== er || rd_g !== eg || rd_b !== eb) begin
      failures++;
      $display("FAIL rd_return: valid=%b client=%b r=%h want 1 1 %h", rd_valid, rd_client, rd_r, er);
    end
    cyc();
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_single: rd_valid=%b want 0 after one return", rd_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] got, want;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 10'd20;
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 10'd21;
    want = 12'b10_01_10_01_10_01;
    got = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      got = {got[9:0], c0_gnt, c1_gnt};
      cyc();
    end
    c0_req = 1'b0; c1_req = 1'b0;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL round_robin: grants {c0,c1}x6=%b want %b", got, want);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_clear();
    int busy, bad_gnt, bad_wr;
    logic ok, vld, cl;
    logic [255:0] r, g, b;
    clr_r = 8'h12; clr_g = 8'h34; clr_b = 8'h56;
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 10'd500;
    c0_r = {32{8'h5A}}; c0_g = {32{8'h5B}}; c0_b = {32{8'h5C}};
    clr_start = 1'b1;
    #1;
    checks++;
    if (c0_gnt !== 1'b0 || mem_clk_en !== 1'b0 || clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_start_cycle: gnt0=%b en=%b busy=%b want 0 0 0", c0_gnt, mem_clk_en, clr_busy);
    end
    cyc();
    clr_start = 1'b0;
    busy = 0; bad_gnt = 0; bad_wr = 0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (!clr_busy) break;
      if (c0_gnt || c1_gnt) bad_gnt++;
      if (mem_addr !== busy[9:0] || mem_wren !== 1'b1 || mem_clk_en !== 1'b1 ||
          mem_r !== {32{8'h12}} || mem_g !== {32{8'h34}} || mem_b !== {32{8'h56}}) bad_wr++;
      busy++;
      clr_start = (busy == 500);
      cyc();
    end
    clr_start = 1'b0;
    checks++;
    if (busy != 1024) begin
      failures++;
      $display("FAIL clr_busy_len: busy cycles=%0d want 1024", busy);
    end
    checks++;
    if (clr_done !== 1'b1 || c0_gnt !== 1'b0) begin
      failures++;
      $display("FAIL clr_done_cycle: done=%b gnt0=%b want 1 0", clr_done, c0_gnt);
    end
    checks++;
    if (bad_gnt != 0 || bad_wr != 0) begin
      failures++;
      $display("FAIL clr_sweep: bad grant cycles=%0d bad write cycles=%0d want 0 0", bad_gnt, bad_wr);
    end
    cyc();
    #1;
    checks++;
    if (c0_gnt !== 1'b1 || clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_wait_grant: gnt0=%b done=%b busy=%b want 1 0 0", c0_gnt, clr_done, clr_busy);
    end
    cyc();
    c0_req = 1'b0;
    do_read(10'd0, ok, vld, cl, r, g, b);
    checks++;
    if (!ok || vld !== 1'b1 || r !== {32{8'h12}} || g !== {32{8'h34}} || b !== {32{8'h56}}) begin
      failures++;
      $display("FAIL clr_word0: gnt=%b valid=%b r=%h g=%h b=%h want 1 1 12.. 34.. 56..", ok, vld, r, g, b);
    end
    do_read(10'd1023, ok, vld, cl, r, g, b);
    checks++;
    if (!ok || vld !== 1'b1 || r !== {32{8'h12}} || g !== {32{8'h34}} || b !== {32{8'h56}}) begin
      failures++;
      $display("FAIL clr_word1023: gnt=%b valid=%b r=%h g=%h b=%h want 1 1 12.. 34.. 56..", ok, vld, r, g, b);
    end
  endtask

  task automatic test_read_into_clear();
    logic ok;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 10'd500;
    #1;
    checks++;
    if (c1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL pre_clear_grant: gnt1=%b want 1", c1_gnt);
    end
    cyc();
    c1_req = 1'b0;
    clr_r = 8'h77; clr_g = 8'h78; clr_b = 8'h79;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b1 || rd_valid !== 1'b1 || rd_client !== 1'b1 ||
        rd_r !== {32{8'h5A}} || rd_g !== {32{8'h5B}} || rd_b !== {32{8'h5C}}) begin
      failures++;
      $display("FAIL read_into_clear: busy=%b valid=%b client=%b r=%h want 1 1 1 5a..",
               clr_busy, rd_valid, rd_client, rd_r);
    end
    wait_clear_end(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clear2_timeout: clr_done seen=%b want 1", ok);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic ok, vld, cl, seen;
    logic [255:0] r, g, b;
    clr_r = 8'hAA; clr_g = 8'hBB; clr_b = 8'hCC;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      #1;
      if (clr_busy && mem_addr == 10'd300) begin seen = 1'b1; break; end
      cyc();
    end
    reset = 1'b1;
    cyc();
    #1;
    checks++;
    if (!seen || {c0_gnt, c1_gnt, rd_valid, clr_busy, clr_done, mem_clk_en, mem_wren} !== 7'h00 ||
        mem_addr !== 10'd0 || mem_r !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: reached300=%b ctrl=%b addr=%0d want 1 0000000 0", seen,
               {c0_gnt, c1_gnt, rd_valid, clr_busy, clr_done, mem_clk_en, mem_wren}, mem_addr);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      if (clr_done || clr_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_done: clr_done/busy seen after reset=%b want 0", seen);
    end
    do_read(10'd299, ok, vld, cl, r, g, b);
    checks++;
    if (!ok || vld !== 1'b1 || r !== {32{8'hAA}} || g !== {32{8'hBB}} || b !== {32{8'hCC}}) begin
      failures++;
      $display("FAIL partial_299: valid=%b r=%h want 1 aa..", vld, r);
    end
    do_read(10'd301, ok, vld, cl, r, g, b);
    checks++;
    if (!ok || vld !== 1'b1 || r !== {32{8'h77}} || g !== {32{8'h78}} || b !== {32{8'h79}}) begin
      failures++;
      $display("FAIL partial_301: valid=%b r=%h want 1 77..", vld, r);
    end
    do_read(10'd1023, ok, vld, cl, r, g, b);
    checks++;
    if (!ok || vld !== 1'b1 || r !== {32{8'h77}} || b !== {32{8'h79}}) begin
      failures++;
      $display("FAIL partial_1023: valid=%b r=%h want 1 77..", vld, r);
    end
  endtask

  initial begin
    reset = 1'b1;
    c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_r = '0; c0_g = '0; c0_b = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_r = '0; c1_g = '0; c1_b = '0;
    clr_start = 1'b0; clr_r = '0; clr_g = '0; clr_b = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear();
    test_read_into_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
